// File: rtl/fifo_rd_drain.sv
// Read-side drain for the synchronous FIFO. It issues credit-limited reads, absorbs the
// one-cycle read latency and re-presents the words on a valid/ready stream through a skid buffer.
module fifo_rd_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      occ;
    logic                  inflight;
    logic                  pop;
    logic [OCC_W:0]        credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1))
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    assign m_valid = (occ != '0);
    assign m_data  = buf_mem[head];
    assign pop     = m_valid && m_ready;

    // Slots already claimed by buffered plus in-flight words, minus the one leaving this cycle.
    assign credit_used = {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);

    assign fifo_rd_en = enable && !fifo_empty && !reset
                        && (credit_used < (OCC_W + 1)'(BUF_DEPTH));
    assign fifo_cs    = fifo_rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            rd_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                buf_mem[i] <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (inflight) begin
                buf_mem[tail] <= fifo_data_out;
                tail          <= ptr_inc(tail);
            end
            if (pop)
                head <= ptr_inc(head);
            case ({inflight, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            rd_count <= rd_count + CNT_WIDTH'(pop);
        end
    end

    // A capture into a full buffer would mean the credit rule is broken.
    always_ff @(posedge clk) begin
        if (!reset && inflight && !pop)
            assert (occ < OCC_W'(BUF_DEPTH))
            else $error("fifo_rd_drain: skid buffer overflow");
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO environment plus a queue-based reference of the
// credit/skid behaviour, directed scenarios followed by a randomized phase.
module tb_fifo_rd_drain;

    localparam int DW = 32;
    localparam int BD = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_cs;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    fifo_rd_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fifo_cs(fifo_cs),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] delivered[$];
    int            m_infl;
    logic [DW-1:0] m_infl_word;
    int            m_cnt;
    int            checks = 0;
    int            fails  = 0;
    int            n_rd;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: compare at negedge, advance model and FIFO environment just after posedge.
    task automatic cycle();
        logic          exp_valid;
        logic          exp_pop;
        logic          exp_rd;
        logic          rd_s;
        logic [DW-1:0] exp_word;
        @(negedge clk);
        if (reset) begin
            mq.delete();
            m_infl = 0;
            m_cnt  = 0;
        end
        exp_valid = (mq.size() > 0);
        exp_pop   = exp_valid && m_ready;
        exp_rd    = enable && (fifo_q.size() > 0) && !reset
                    && ((mq.size() + m_infl - int'(exp_pop)) < BD);
        exp_word  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        chk("m_valid", {31'b0, m_valid}, {31'b0, exp_valid});
        chk("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_rd});
        chk("fifo_cs", {31'b0, fifo_cs}, {31'b0, exp_rd});
        chk("rd_count", DW'(rd_count), DW'(m_cnt));
        if (exp_valid)
            chk("m_data", m_data, mq[0]);
        else if (reset)
            chk("m_data_reset", m_data, '0);
        rd_s = fifo_rd_en;
        if (fifo_rd_en) n_rd++;
        if (m_valid && m_ready) delivered.push_back(m_data);
        @(posedge clk);
        #1;
        if (!reset) begin
            if (exp_pop) void'(mq.pop_front());
            if (m_infl != 0) mq.push_back(m_infl_word);
            m_infl      = exp_rd ? 1 : 0;
            m_infl_word = exp_word;
            m_cnt       = (m_cnt + int'(exp_pop)) % (1 << CW);
        end
        if (rd_s && fifo_q.size() > 0)
            fifo_data_out = fifo_q.pop_front();
        else
            fifo_data_out = $urandom;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        m_ready       = 1'b1;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        m_infl        = 0;
        m_infl_word   = '0;
        m_cnt         = 0;
        for (int i = 0; i < 4; i++) push(32'hA0 + i);

        // Reset held with a non-empty FIFO
        repeat (3) cycle();
        reset = 1'b0;

        // Streaming
        n_rd = 0;
        delivered.delete();
        repeat (8) cycle();
        chk("stream_reads", DW'(n_rd), 4);
        chk("stream_words", DW'(delivered.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < delivered.size()) chk("stream_order", delivered[i], 32'hA0 + i);
        chk("stream_count", DW'(rd_count), 4);

        // Backpressure
        pulse_reset();
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        m_ready = 1'b0;
        n_rd = 0;
        repeat (10) cycle();
        chk("bp_reads", DW'(n_rd), BD);
        chk("bp_hold_valid", {31'b0, m_valid}, 1);
        chk("bp_hold_data", m_data, 32'hA0);
        m_ready = 1'b1;
        delivered.delete();
        repeat (6) cycle();
        chk("bp_words", DW'(delivered.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < delivered.size()) chk("bp_order", delivered[i], 32'hA0 + i);

        // Empty FIFO
        n_rd = 0;
        repeat (20) cycle();
        chk("empty_reads", DW'(n_rd), 0);

        // Enable drop after two read pulses
        for (int i = 0; i < 4; i++) push(32'hA0 + i);
        n_rd = 0;
        delivered.delete();
        repeat (2) cycle();
        enable = 1'b0;
        repeat (6) cycle();
        chk("endrop_reads", DW'(n_rd), 2);
        chk("endrop_words", DW'(delivered.size()), 2);
        for (int i = 0; i < 2; i++)
            if (i < delivered.size()) chk("endrop_order", delivered[i], 32'hA0 + i);
        enable = 1'b1;
        repeat (6) cycle();
        chk("enresume_words", DW'(delivered.size()), 4);
        for (int i = 2; i < 4; i++)
            if (i < delivered.size()) chk("enresume_order", delivered[i], 32'hA0 + i);

        // Counter wrap: 17 words with a 4-bit counter
        pulse_reset();
        for (int i = 0; i < 17; i++) push(32'h100 + i);
        repeat (25) cycle();
        chk("wrap_count", DW'(rd_count), 1);

        // Reset with two words buffered
        m_ready = 1'b0;
        push(32'hB0);
        push(32'hB1);
        repeat (4) cycle();
        chk("pre_rst_valid", {31'b0, m_valid}, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {31'b0, m_valid}, 0);
        chk("rst_async_count", DW'(rd_count), 0);
        cycle();
        reset   = 1'b0;
        m_ready = 1'b1;
        push(32'hC0);
        delivered.delete();
        repeat (6) cycle();
        chk("post_rst_words", DW'(delivered.size()), 1);
        if (delivered.size() > 0) chk("post_rst_word", delivered[0], 32'hC0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) push($urandom);
            enable  = ($urandom_range(0, 7) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            reset   = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (40) cycle();
        chk("final_drained", {31'b0, m_valid}, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer placed directly downstream of the team's synchronous FIFO.
- Drives the FIFO chip-select and read-enable, absorbs the FIFO's one-cycle read latency, and re-presents the words on a valid/ready stream through a small skid buffer.
- Downstream stalls therefore never drop or duplicate a word.
- Counts words delivered.

Parameters:
- DATA_WIDTH, 32, FIFO/stream word width.
- BUF_DEPTH, 2, skid buffer entries (≥2).
- CNT_WIDTH, 16, delivered-word counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permit new FIFO reads.
- fifo_cs  out  1  FIFO chip-select.
- fifo_rd_en  out  1  FIFO read request.
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  stream word.
- rd_count  out  CNT_WIDTH  words delivered (m_valid && m_ready).

Behaviour:
- Reset (async assert, sync release): buffer occupancy=0, in-flight flag=0, m_valid=0, m_data=0, rd_count=0, fifo_rd_en=0, fifo_cs=0.
- pop = m_valid && m_ready.
- fifo_rd_en (combinational) = enable && !fifo_empty && !reset && (occ + inflight − pop) < BUF_DEPTH.
- fifo_cs = fifo_rd_en; the block never asserts cs without rd_en.
- inflight = fifo_rd_en registered. While inflight=1, fifo_data_out is written into the buffer tail at the clock edge.
- The credit rule guarantees no overflow. An overflow write is a design error; assert it in simulation.
- Latency: fifo_rd_en high in cycle N → capture at end of N+1 → m_valid high in cycle N+2.
- Throughput: one word/cycle sustained when the FIFO is non-empty and m_ready=1.
- m_valid = (occ>0); m_data = head entry.
- While m_valid && !m_ready, m_data must stay stable and m_valid stays high.
- Word order is strictly preserved.
- Simultaneous capture and pop in one cycle: occ unchanged, head advances.
- enable low: no new reads. The in-flight word is still captured, and the buffer keeps draining to downstream.
- fifo_empty high: no read issued. Reads resume in the same cycle fifo_empty falls, subject to credit.
- rd_count increments on each pop and wraps modulo 2^CNT_WIDTH without saturating.
- Reset mid-operation: all state clears immediately; buffered and in-flight words are discarded.

Test Plan:
- Reset: assert reset for 3 cycles with FIFO non-empty → fifo_rd_en=0, fifo_cs=0, m_valid=0, rd_count=0 throughout reset.
- Streaming: FIFO preloaded 0xA0,0xA1,0xA2,0xA3, enable=1, m_ready=1 → fifo_rd_en high cycles 0–3; m_data 0xA0..0xA3 in cycles 2–5; m_valid low from cycle 6; rd_count=4.
- Backpressure: same preload, m_ready=0 → exactly BUF_DEPTH=2 read pulses; m_valid=1 with m_data=0xA0 held stable. Raise m_ready at cycle 10 → 0xA0..0xA3 delivered in order on cycles 10–13.
- Empty FIFO: fifo_empty=1, enable=1 for 20 cycles → fifo_rd_en never asserted, m_valid stays 0.
- Enable drop: 4 words preloaded, m_ready=1, enable falls after the 2nd read pulse → exactly 2 words delivered (0xA0, 0xA1). Re-assert enable → 0xA2, 0xA3 follow.
- Reset mid-burst / counter wrap: CNT_WIDTH=4, deliver 17 words → rd_count=1. Pulse reset with 2 words buffered → m_valid=0 next cycle, rd_count=0, and those 2 words are never presented.
